// File: rtl/trig_lut_sched_if.sv
// ============================================================================
// Module   : trig_lut_sched_if
// Brief    : Request/response and shared-sine-table bundle for trig_lut_sched.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface trig_lut_sched_if #(
    parameter int NREQ = 3,
    parameter int AW   = 10,
    parameter int DW   = 8,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]        req;
    logic [NREQ*AW-1:0]     angle_in;
    logic [NREQ-1:0]        cos_sel;
    logic [NREQ-1:0]        ack;
    logic [AW-1:0]          lut_angle;
    logic signed [DW-1:0]   lut_data;
    logic                   rsp_valid;
    logic [IDW-1:0]         rsp_id;
    logic signed [DW-1:0]   rsp_data;
    logic                   busy;

    // The environment side owns both the requesters and the sine table itself.
    modport master (
        output req, angle_in, cos_sel, lut_data,
        input  ack, lut_angle, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req, angle_in, cos_sel, lut_data,
        output ack, lut_angle, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

`default_nettype wire

// File: rtl/trig_lut_sched.sv
// ============================================================================
// Module   : trig_lut_sched
// Brief    : Round-robin scheduler sharing one sine table between NREQ angle
//            requesters; optional cosine offset enabled by macro TRIG_COS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trig_lut_sched #(
    parameter int NREQ = 3,
    parameter int AW   = 10,
    parameter int DW   = 8,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    trig_lut_sched_if.slave     bus
);

`ifdef TRIG_COS_EN
    // One extra bit so angle+90 cannot wrap before normalisation.
    localparam int WW = AW + 1;
`else
    localparam int WW = AW;
`endif

    localparam logic [WW-1:0] C_FULL_TURN = WW'(360);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NORM = 2'd1;
    localparam logic [1:0] S_LOOK = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [WW-1:0]          work_q, work_d;
    logic [IDW-1:0]         id_q, id_d;
    logic [NREQ-1:0]        ack_q, ack_d;
    logic [AW-1:0]          lut_angle_q, lut_angle_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]         rsp_id_q, rsp_id_d;
    logic signed [DW-1:0]   rsp_data_q, rsp_data_d;
    logic                   busy_q, busy_d;

    logic                   w_grant_vld;
    logic [IDW-1:0]         w_grant_idx;
    logic [IDW:0]           w_cand;
    logic [IDW:0]           w_rr_inc;
    logic [IDW-1:0]         w_rr_next;
    logic [AW-1:0]          w_sel_angle;
    logic [WW-1:0]          w_start_work;

    // First pending requester at or after rr_ptr, wrapping at NREQ.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (w_cand >= (IDW+1)'(NREQ)) begin
                w_cand = w_cand - (IDW+1)'(NREQ);
            end
            if (!w_grant_vld && bus.req[w_cand[IDW-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_rr_inc  = {1'b0, w_grant_idx} + (IDW+1)'(1);
        w_rr_next = (w_rr_inc >= (IDW+1)'(NREQ)) ? '0 : w_rr_inc[IDW-1:0];
    end

    assign w_sel_angle = bus.angle_in[int'(w_grant_idx)*AW +: AW];

`ifdef TRIG_COS_EN
    assign w_start_work = WW'(w_sel_angle)
                        + (bus.cos_sel[w_grant_idx] ? WW'(90) : WW'(0));
`else
    logic w_unused_cos;
    assign w_unused_cos = ^bus.cos_sel;
    assign w_start_work = WW'(w_sel_angle);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_grant_vld) state_d = S_NORM;
            S_NORM:  if (work_q < C_FULL_TURN) state_d = S_LOOK;
            S_LOOK:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        work_d      = work_q;
        id_d        = id_q;
        ack_d       = '0;
        lut_angle_d = lut_angle_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (w_grant_vld) begin
                    ack_d    = NREQ'(1) << w_grant_idx;
                    work_d   = w_start_work;
                    id_d     = w_grant_idx;
                    rr_ptr_d = w_rr_next;
                end
            end
            S_NORM: begin
                if (work_q >= C_FULL_TURN) begin
                    work_d = work_q - C_FULL_TURN;
                end else begin
                    lut_angle_d = work_q[AW-1:0];
                end
            end
            S_LOOK: begin
                rsp_data_d  = bus.lut_data;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                lut_angle_d = '0;
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            work_q      <= '0;
            id_q        <= '0;
            ack_q       <= '0;
            lut_angle_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            work_q      <= work_d;
            id_q        <= id_d;
            ack_q       <= ack_d;
            lut_angle_q <= lut_angle_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.lut_angle = lut_angle_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_trig_lut_sched.sv
// ============================================================================
// Module   : tb_trig_lut_sched
// Brief    : Scoreboard bench for trig_lut_sched (honours TRIG_COS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_trig_lut_sched;
    localparam int NREQ = 3;
    localparam int AW   = 10;
    localparam int DW   = 8;
    localparam int IDW  = 2;
`ifdef TRIG_COS_EN
    localparam bit COS_EN = 1'b1;
`else
    localparam bit COS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trig_lut_sched_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) bus ();

    trig_lut_sched #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int id;
        int ang;
        int data;
        int lat;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   prev_lut = 0;

    function automatic int sin100(input int a);
        real r;
        r = $sin(real'(a) * 3.14159265358979 / 180.0) * 100.0;
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    // Reference normalisation: optional +90, then repeated -360.
    function automatic int norm_angle(input int a, input bit c, output int nsub);
        int w;
        w    = a + ((COS_EN && c) ? 90 : 0);
        nsub = 0;
        while (w >= 360) begin
            w    = w - 360;
            nsub = nsub + 1;
        end
        return w;
    endfunction

    always_comb bus.lut_data = DW'(sin100(int'(bus.lut_angle)));

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
                check_val("unexpected_rsp", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check_val("rsp_id",    int'(bus.rsp_id), mon_e.id);
                check_val("rsp_data",  int'($signed(bus.rsp_data)), mon_e.data);
                check_val("lut_angle", prev_lut, mon_e.ang);
                check_val("latency",   cyc - mon_e.cyc, mon_e.lat);
            end
        end
        prev_lut = int'(bus.lut_angle);
    end

    task automatic wait_ack(input logic [NREQ-1:0] exp_ack, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.ack == '0 && n < 30);
        check_val({tag, "_ack"},  int'(bus.ack), int'(exp_ack));
        check_val({tag, "_busy"}, int'(bus.busy), 1);
    endtask

    task automatic push_exp(input int id, input int ang, input bit c, input int data);
        exp_t e;
        int   nsub;
        e.id   = id;
        e.ang  = norm_angle(ang, c, nsub);
        e.data = data;
        e.lat  = 2 + nsub;
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_val("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic serve(input int id, input int ang, input bit c, input int data, input string tag);
        bus.angle_in[id*AW +: AW] = AW'(ang);
        bus.cos_sel[id]           = c;
        bus.req[id]               = 1'b1;
        wait_ack(NREQ'(1) << id, tag);
        push_exp(id, ang, c, data);
        bus.req[id]     = 1'b0;
        bus.cos_sel[id] = 1'b0;
        drain();
    endtask

    initial begin
        int id, ang, nsub, na;
        bit c;

        // Three requests held from reset.
        bus.angle_in = {10'd270, 10'd180, 10'd90};
        bus.cos_sel  = '0;
        bus.req      = 3'b111;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_ack",       int'(bus.ack), 0);
        check_val("rst_rsp_valid", int'(bus.rsp_valid), 0);
        check_val("rst_rsp_id",    int'(bus.rsp_id), 0);
        check_val("rst_rsp_data",  int'($signed(bus.rsp_data)), 0);
        check_val("rst_lut_angle", int'(bus.lut_angle), 0);
        check_val("rst_busy",      int'(bus.busy), 0);
        rst = 1'b0;

        for (int k = 0; k < 3; k++) begin
            wait_ack(NREQ'(1) << k, "rr");
            push_exp(k, 90 * (k + 1), 1'b0, (k == 0) ? 100 : (k == 1) ? 0 : -100);
            bus.req[k] = 1'b0;
        end
        drain();

        serve(0, 30,   1'b0, 50,  "t1");
        serve(1, 390,  1'b0, 50,  "t2");
        serve(2, 0,    1'b1, COS_EN ? 100 : 0, "t4");
        serve(0, 1023, 1'b0, -84, "t5");
        serve(1, 360,  1'b0, 0,   "b360");
        serve(2, 720,  1'b0, 0,   "b720");
        serve(0, 270,  1'b1, COS_EN ? 0 : -100, "bcos270");

        for (int k = 0; k < 10; k++) begin
            id  = $urandom_range(NREQ - 1, 0);
            ang = $urandom_range(1023, 0);
            c   = 1'($urandom_range(1, 0));
            na  = norm_angle(ang, c, nsub);
            serve(id, ang, c, sin100(na), "rand");
        end

        // Reset while normalising aborts the lookup and clears rr_ptr.
        bus.angle_in[1*AW +: AW] = 10'd1023;
        bus.req[1]               = 1'b1;
        wait_ack(3'b010, "t6_abort");
        bus.req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("t6_rst_ack",       int'(bus.ack), 0);
        check_val("t6_rst_rsp_valid", int'(bus.rsp_valid), 0);
        check_val("t6_rst_rsp_data",  int'($signed(bus.rsp_data)), 0);
        check_val("t6_rst_rsp_id",    int'(bus.rsp_id), 0);
        check_val("t6_rst_lut_angle", int'(bus.lut_angle), 0);
        check_val("t6_rst_busy",      int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        bus.angle_in[1*AW +: AW] = 10'd30;
        bus.angle_in[2*AW +: AW] = 10'd270;
        bus.req = 3'b110;
        wait_ack(3'b010, "t6_first");
        push_exp(1, 30, 1'b0, 50);
        bus.req[1] = 1'b0;
        wait_ack(3'b100, "t6_second");
        push_exp(2, 270, 1'b0, -100);
        bus.req[2] = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
